vme_param_arbiter: RTL and testbench
====================================

# vme_param_arbiter

Parametrised VME bus arbiter for NUM_REQ requesters. It supports single-level, fixed-priority and round-robin arbitration and holds a grant until the winning master releases BBSY. A grant-acknowledge timeout prevents bus lock-up. It sits between the requester bus_req lines and the system bus-busy line, and replaces the fixed 4-requester arbiter.

## Interface
- NUM_REQ, 4: number of requesters, legal range 2..16; index NUM_REQ-1 has the highest priority.
- ID_W, $clog2(NUM_REQ): width of grant_id.
- TIMEOUT_CYC, 200: cycles allowed between grant and bbsy_in assertion, legal range 1..65535.
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- bus_req  in  NUM_REQ  request lines, level-sensitive, one bit per master.
- mode  in  2  00 single (only NUM_REQ-1 eligible), 01 fixed priority, 10 round robin, 11 reserved (no grants).
- bbsy_in  in  1  bus-busy driven by the current owner.
- bus_grant  out  NUM_REQ  one-hot grant, or all zero.
- grant_id  out  ID_W  index of the current or last grantee.
- bus_busy  out  1  high whenever state != IDLE.
- timeout  out  1  one-cycle pulse when a grant is withdrawn by the timeout.

## Operation
- Reset: state IDLE; bus_grant=0, grant_id=0, bus_busy=0, timeout=0; rr_last=0, mode_q=00, timer=0.
- States: IDLE, GRANT, OWNED, RELEASE.
- IDLE:
  - mode_q <= mode every cycle; mode is sampled only in IDLE.
  - A mode change while not IDLE takes effect at the next IDLE cycle.
  - The winner is computed combinationally from bus_req and the current mode input.
  - If there is a winner: bus_grant <= onehot(winner), grant_id <= winner, timer <= 0, go to GRANT.
- Winner selection:
  - 00: the winner is NUM_REQ-1 if bus_req[NUM_REQ-1] is set; otherwise there is no winner.
  - 01: the winner is the highest set index.
  - 10: search starts at (rr_last-1) mod NUM_REQ and descends with wrap; the first set bit wins. rr_last <= winner on grant issue.
  - 11: no winner, ever.
- GRANT:
  - If bbsy_in=1: go to OWNED; the grant stays asserted.
  - Else if bus_req[grant_id]=0: the requester withdrew. bus_grant <= 0, go to RELEASE, no timeout pulse.
  - Else if timer == TIMEOUT_CYC-1: bus_grant <= 0, timeout <= 1 for one cycle, go to RELEASE.
  - Else timer increments. Its width is sized to hold TIMEOUT_CYC-1; it does not wrap.
- OWNED:
  - bus_req is ignored; only bbsy_in matters.
  - When bbsy_in=0: bus_grant <= 0, go to RELEASE.
- RELEASE: one dead cycle, grant held low, then IDLE.
- Simultaneous events:
  - In GRANT, bbsy_in=1 takes precedence over request withdrawal and over timeout expiry in the same cycle.
  - rst has precedence over everything and takes effect on the next edge from any state.
- grant_id holds its value through RELEASE and IDLE until the next grant.
- Round robin: rr_last also updates on grants that later time out or are withdrawn.

## Timing
- All outputs are registered.
- Request sampled in IDLE at edge t: bus_grant and bus_busy are valid after edge t.
- bbsy_in falls, sampled in OWNED at edge t:
  - bus_grant=0 after t, in RELEASE.
  - IDLE after t+1.
  - The earliest next grant is after t+2.
- Timeout: grant issued at edge g, bbsy_in held low, request held.
  - bus_grant drops and timeout pulses after edge g+TIMEOUT_CYC.
- bus_busy goes high with the grant and low on entry to IDLE.

## Test plan
- Reset mid-OWNED: NUM_REQ=4, rst=1 for one cycle while state=OWNED.
  - Required response: all outputs 0 the next cycle.
  - With bus_req=4'b0001 and mode=10 held, the first grant is 4'b0001 (search starts at index 3).
- Fixed priority: mode=01, bus_req=4'b0110.
  - Required response: bus_grant=4'b0100 and grant_id=2 one cycle later.
  - bbsy_in pulses high then low → bus_grant=0 in the cycle after the fall.
  - bus_req=4'b0010 → bus_grant=4'b0010 two cycles after RELEASE.
- Round robin: mode=10, bus_req=4'b1111; each grant is acknowledged by bbsy_in for 2 cycles and then released.
  - Required response: grant_id sequence 3,2,1,0,3.
  - With bus_req=4'b1001 the sequence is 3,0,3.
- Single mode: mode=00, bus_req=4'b0111.
  - Required response: no grant; bus_busy stays 0.
  - Setting bus_req[3] → bus_grant=4'b1000.
- Timeout: TIMEOUT_CYC=5, mode=01, bus_req=4'b0001, bbsy_in held 0.
  - Required response: the grant is high for exactly 5 cycles.
  - timeout pulses once; the grant reissues 2 cycles later.
- Mode change while OWNED: change 01→10 during OWNED.
  - Required response: the current grant is unaffected.
  - Arbitration after RELEASE uses round robin; mode=11 yields no grant.

Source files
------------

// File: rtl/vme_param_arbiter.sv
// -----------------------------------------------------------------------------
// vme_param_arbiter
//
// Parametrised VME bus arbiter for NUM_REQ requesters. Supports single-level
// (only the top requester may win), fixed-priority and round-robin arbitration.
// A grant is held until the winning master raises and then drops bbsy_in.
// A grant that is never acknowledged is withdrawn after TIMEOUT_CYC cycles so
// a dead master cannot lock the bus.
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   synchronous, active-high reset
//   bus_req    in   [NUM_REQ]  level-sensitive request lines
//   mode       in   [2]  00 single, 01 fixed priority, 10 round robin, 11 none
//   bbsy_in    in   bus-busy from the current owner
//   bus_grant  out  [NUM_REQ]  one-hot grant or all zero
//   grant_id   out  [ID_W]  index of the current or most recent grantee
//   bus_busy   out  high whenever the arbiter is not idle
//   timeout    out  one-cycle pulse when a grant is withdrawn by the timer
// -----------------------------------------------------------------------------
module vme_param_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = $clog2(NUM_REQ),
    parameter int TIMEOUT_CYC = 200
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] bus_req,
    input  logic [1:0]         mode,
    input  logic               bbsy_in,
    output logic [NUM_REQ-1:0] bus_grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               bus_busy,
    output logic               timeout
);

    // Timer only has to reach TIMEOUT_CYC-1; keep at least one bit.
    localparam int                TIMER_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_OWNED,
        ST_RELEASE
    } state_t;

    state_t               state_q,   state_d;
    logic [NUM_REQ-1:0]   grant_q,   grant_d;
    logic [ID_W-1:0]      id_q,      id_d;
    logic [ID_W-1:0]      rr_last_q, rr_last_d;
    logic [1:0]           mode_q,    mode_d;
    logic [TIMER_W-1:0]   timer_q,   timer_d;
    logic                 timeout_q, timeout_d;
    logic                 busy_q,    busy_d;

    // Arbitration helpers
    logic [1:0]           mode_sel;
    int                   rr_start;
    logic [ID_W-1:0]      rr_idx;
    logic                 win_valid;
    logic [ID_W-1:0]      win_idx;
    logic [NUM_REQ-1:0]   win_onehot;

    // In IDLE the live mode input decides; elsewhere the mode latched on the
    // last idle cycle is presented, so a mode change mid-tenure is only seen
    // once the arbiter is back in IDLE.
    assign mode_sel = (state_q == ST_IDLE) ? mode : mode_q;

    // Round-robin search starts just below the previous winner, wrapping.
    assign rr_start = (rr_last_q == '0) ? (NUM_REQ - 1) : (int'(rr_last_q) - 1);

    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        rr_idx    = '0;
        case (mode_sel)
            2'b00: begin
                if (bus_req[NUM_REQ-1]) begin
                    win_valid = 1'b1;
                    win_idx   = ID_W'(NUM_REQ - 1);
                end
            end
            2'b01: begin
                // Ascending scan; the last hit is the highest set index.
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (bus_req[ID_W'(i)]) begin
                        win_valid = 1'b1;
                        win_idx   = ID_W'(i);
                    end
                end
            end
            2'b10: begin
                // Walk the search order backwards so the hit nearest the
                // start position is the one left standing.
                for (int i = NUM_REQ - 1; i >= 0; i--) begin
                    rr_idx = ID_W'((rr_start + NUM_REQ - i) % NUM_REQ);
                    if (bus_req[rr_idx]) begin
                        win_valid = 1'b1;
                        win_idx   = rr_idx;
                    end
                end
            end
            default: begin
                win_valid = 1'b0;
            end
        endcase
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
        assign win_onehot[gi] = (win_idx == ID_W'(gi));
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        id_d      = id_q;
        rr_last_d = rr_last_q;
        mode_d    = mode_q;
        timer_d   = timer_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                mode_d = mode;
                if (win_valid) begin
                    grant_d = win_onehot;
                    id_d    = win_idx;
                    timer_d = '0;
                    state_d = ST_GRANT;
                    // Recorded even if this grant later times out or is withdrawn.
                    if (mode == 2'b10) begin
                        rr_last_d = win_idx;
                    end
                end
            end
            ST_GRANT: begin
                // Acknowledge wins over withdrawal and expiry in the same cycle.
                if (bbsy_in) begin
                    state_d = ST_OWNED;
                end else if (!bus_req[id_q]) begin
                    grant_d = '0;
                    state_d = ST_RELEASE;
                end else if (timer_q == TIMER_LAST) begin
                    grant_d   = '0;
                    timeout_d = 1'b1;
                    state_d   = ST_RELEASE;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            ST_OWNED: begin
                if (!bbsy_in) begin
                    grant_d = '0;
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            id_q      <= '0;
            rr_last_q <= '0;
            mode_q    <= 2'b00;
            timer_q   <= '0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            id_q      <= id_d;
            rr_last_q <= rr_last_d;
            mode_q    <= mode_d;
            timer_q   <= timer_d;
            timeout_q <= timeout_d;
            busy_q    <= busy_d;
        end
    end

    assign bus_grant = grant_q;
    assign grant_id  = id_q;
    assign bus_busy  = busy_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_vme_param_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vme_param_arbiter
//
// Directed bench for vme_param_arbiter (NUM_REQ=4, TIMEOUT_CYC=5). Inputs are
// driven on the falling edge; outputs are checked on the following falling
// edge, i.e. after exactly one rising edge has consumed the inputs.
// -----------------------------------------------------------------------------
module tb_vme_param_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] bus_req;
    logic [1:0] mode;
    logic       bbsy_in;
    logic [3:0] bus_grant;
    logic [1:0] grant_id;
    logic       bus_busy;
    logic       timeout;

    int checks   = 0;
    int failures = 0;

    vme_param_arbiter #(
        .NUM_REQ     (4),
        .ID_W        (2),
        .TIMEOUT_CYC (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus_req   (bus_req),
        .mode      (mode),
        .bbsy_in   (bbsy_in),
        .bus_grant (bus_grant),
        .grant_id  (grant_id),
        .bus_busy  (bus_busy),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        logic       r;
        logic [3:0] req;
        logic [1:0] md;
        logic       bb;
        logic [3:0] eg;
        logic [1:0] eid;
        logic       ebusy;
        logic       eto;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(string nm, logic r, logic [3:0] req, logic [1:0] md, logic bb,
                                logic [3:0] eg, logic [1:0] eid, logic ebusy, logic eto);
        vec_t v;
        v.nm = nm; v.r = r; v.req = req; v.md = md; v.bb = bb;
        v.eg = eg; v.eid = eid; v.ebusy = ebusy; v.eto = eto;
        vecs.push_back(v);
    endfunction

    // Grant issued, acknowledged for two cycles, released, back to idle.
    function automatic void add_tenure(string nm, logic [3:0] req, logic [1:0] md, int id);
        logic [3:0] g;
        logic [1:0] i2;
        i2 = 2'(id);
        g  = 4'b0001 << id;
        add(nm, 0, req, md, 0, g,    i2, 1, 0);
        add(nm, 0, req, md, 1, g,    i2, 1, 0);
        add(nm, 0, req, md, 1, g,    i2, 1, 0);
        add(nm, 0, req, md, 0, 4'b0, i2, 1, 0);
        add(nm, 0, req, md, 0, 4'b0, i2, 0, 0);
    endfunction

    task automatic drive(input logic r, input logic [3:0] req, input logic [1:0] md, input logic bb);
        rst     = r;
        bus_req = req;
        mode    = md;
        bbsy_in = bb;
    endtask

    task automatic check(input string nm, input logic [3:0] eg, input logic [1:0] eid,
                         input logic eb, input logic et);
        checks++;
        if (bus_grant !== eg || grant_id !== eid || bus_busy !== eb || timeout !== et) begin
            failures++;
            $display("FAIL %s: got grant=%b id=%0d busy=%b timeout=%b, want grant=%b id=%0d busy=%b timeout=%b",
                     nm, bus_grant, grant_id, bus_busy, timeout, eg, eid, eb, et);
        end else begin
            $display("ok   %s: grant=%b id=%0d busy=%b timeout=%b", nm, bus_grant, grant_id, bus_busy, timeout);
        end
    endtask

    task automatic step_check(input string nm, input logic [3:0] eg, input logic [1:0] eid,
                              input logic eb, input logic et);
        @(negedge clk);
        check(nm, eg, eid, eb, et);
    endtask

    initial begin
        drive(1, 4'b0000, 2'b01, 0);

        // ---------------- table: reset, fixed priority, RR, single, reset mid-OWNED
        add("reset",          1, 4'b0000, 2'b01, 0, 4'b0000, 2'd0, 0, 0);
        add("fp_grant",       0, 4'b0110, 2'b01, 0, 4'b0100, 2'd2, 1, 0);
        add("fp_owned",       0, 4'b0110, 2'b01, 1, 4'b0100, 2'd2, 1, 0);
        add("fp_release",     0, 4'b0110, 2'b01, 0, 4'b0000, 2'd2, 1, 0);
        add("fp_idle",        0, 4'b0010, 2'b01, 0, 4'b0000, 2'd2, 0, 0);
        add("fp_second",      0, 4'b0010, 2'b01, 0, 4'b0010, 2'd1, 1, 0);
        add("fp_second_own",  0, 4'b0010, 2'b01, 1, 4'b0010, 2'd1, 1, 0);
        add("fp_second_rel",  0, 4'b0000, 2'b01, 0, 4'b0000, 2'd1, 1, 0);
        add("fp_second_idle", 0, 4'b0000, 2'b01, 0, 4'b0000, 2'd1, 0, 0);
        add("reset_rr",       1, 4'b0000, 2'b10, 0, 4'b0000, 2'd0, 0, 0);
        add_tenure("rr1111_a", 4'b1111, 2'b10, 3);
        add_tenure("rr1111_b", 4'b1111, 2'b10, 2);
        add_tenure("rr1111_c", 4'b1111, 2'b10, 1);
        add_tenure("rr1111_d", 4'b1111, 2'b10, 0);
        add_tenure("rr1111_e", 4'b1111, 2'b10, 3);
        add("reset_rr2",      1, 4'b0000, 2'b10, 0, 4'b0000, 2'd0, 0, 0);
        add_tenure("rr1001_a", 4'b1001, 2'b10, 3);
        add_tenure("rr1001_b", 4'b1001, 2'b10, 0);
        add_tenure("rr1001_c", 4'b1001, 2'b10, 3);
        add("single_none1",   0, 4'b0111, 2'b00, 0, 4'b0000, 2'd3, 0, 0);
        add("single_none2",   0, 4'b0111, 2'b00, 0, 4'b0000, 2'd3, 0, 0);
        add("single_none3",   0, 4'b0111, 2'b00, 0, 4'b0000, 2'd3, 0, 0);
        add("single_win",     0, 4'b1111, 2'b00, 0, 4'b1000, 2'd3, 1, 0);
        add("single_own",     0, 4'b1111, 2'b00, 1, 4'b1000, 2'd3, 1, 0);
        add("single_rel",     0, 4'b0000, 2'b00, 0, 4'b0000, 2'd3, 1, 0);
        add("single_idle",    0, 4'b0000, 2'b00, 0, 4'b0000, 2'd3, 0, 0);
        add("rst_pre_grant",  0, 4'b0100, 2'b01, 0, 4'b0100, 2'd2, 1, 0);
        add("rst_pre_owned",  0, 4'b0100, 2'b01, 1, 4'b0100, 2'd2, 1, 0);
        add("rst_mid_owned",  1, 4'b0001, 2'b10, 1, 4'b0000, 2'd0, 0, 0);
        add("rst_rr_first",   0, 4'b0001, 2'b10, 0, 4'b0001, 2'd0, 1, 0);
        add("withdraw_rel",   0, 4'b0000, 2'b10, 0, 4'b0000, 2'd0, 1, 0);
        add("withdraw_idle",  0, 4'b0000, 2'b10, 0, 4'b0000, 2'd0, 0, 0);

        foreach (vecs[k]) begin
            drive(vecs[k].r, vecs[k].req, vecs[k].md, vecs[k].bb);
            @(negedge clk);
            check(vecs[k].nm, vecs[k].eg, vecs[k].eid, vecs[k].ebusy, vecs[k].eto);
        end

        // ---------------- timeout: grant lasts exactly 5 cycles, pulse, regrant
        drive(0, 4'b0001, 2'b01, 0);
        for (int k = 0; k < 5; k++) step_check("to_hold", 4'b0001, 2'd0, 1, 0);
        step_check("to_pulse",   4'b0000, 2'd0, 1, 1);
        step_check("to_idle",    4'b0000, 2'd0, 0, 0);
        step_check("to_regrant", 4'b0001, 2'd0, 1, 0);

        // ---------------- acknowledge on the expiry cycle beats the timeout
        for (int k = 0; k < 4; k++) step_check("to2_hold", 4'b0001, 2'd0, 1, 0);
        drive(0, 4'b0001, 2'b01, 1);
        step_check("bbsy_over_timeout", 4'b0001, 2'd0, 1, 0);
        drive(0, 4'b0000, 2'b01, 0);
        step_check("to2_rel",  4'b0000, 2'd0, 1, 0);
        step_check("to2_idle", 4'b0000, 2'd0, 0, 0);

        // ---------------- acknowledge beats withdrawal; OWNED ignores bus_req
        drive(0, 4'b0100, 2'b01, 0);
        step_check("pw_grant", 4'b0100, 2'd2, 1, 0);
        drive(0, 4'b0000, 2'b01, 1);
        step_check("bbsy_over_withdraw", 4'b0100, 2'd2, 1, 0);
        step_check("owned_ignores_req",  4'b0100, 2'd2, 1, 0);
        drive(0, 4'b0000, 2'b01, 0);
        step_check("pw_rel",  4'b0000, 2'd2, 1, 0);
        step_check("pw_idle", 4'b0000, 2'd2, 0, 0);

        // ---------------- mode change while OWNED
        drive(0, 4'b1000, 2'b10, 0);
        step_check("mc_rr_seed", 4'b1000, 2'd3, 1, 0);
        drive(0, 4'b1000, 2'b10, 1);
        step_check("mc_rr_own", 4'b1000, 2'd3, 1, 0);
        drive(0, 4'b0000, 2'b10, 0);
        step_check("mc_rr_rel",  4'b0000, 2'd3, 1, 0);
        step_check("mc_rr_idle", 4'b0000, 2'd3, 0, 0);
        drive(0, 4'b1000, 2'b01, 0);
        step_check("mc_fp_grant", 4'b1000, 2'd3, 1, 0);
        drive(0, 4'b1000, 2'b01, 1);
        step_check("mc_fp_own", 4'b1000, 2'd3, 1, 0);
        drive(0, 4'b1100, 2'b10, 1);
        step_check("mc_owned_unaffected1", 4'b1000, 2'd3, 1, 0);
        step_check("mc_owned_unaffected2", 4'b1000, 2'd3, 1, 0);
        drive(0, 4'b1100, 2'b10, 0);
        step_check("mc_rel",  4'b0000, 2'd3, 1, 0);
        step_check("mc_idle", 4'b0000, 2'd3, 0, 0);
        step_check("mc_rr_after", 4'b0100, 2'd2, 1, 0);
        drive(0, 4'b1100, 2'b10, 1);
        step_check("mc_rr_after_own", 4'b0100, 2'd2, 1, 0);
        drive(0, 4'b0000, 2'b11, 0);
        step_check("mc_rr_after_rel",  4'b0000, 2'd2, 1, 0);
        step_check("mc_rr_after_idle", 4'b0000, 2'd2, 0, 0);
        drive(0, 4'b1111, 2'b11, 0);
        for (int k = 0; k < 3; k++) step_check("mode11_no_grant", 4'b0000, 2'd2, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
